// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - command codes, pending-bit layout and priority helpers
//
// Purpose: shared definitions for the button command decoder.
//   CMD_*  : 3-bit command codes driven on cmd.
//   P_*    : bit positions in the pending vector, ordered so that a higher
//            index means higher delivery priority.
//   pend_pick / pend_to_cmd : select the highest-priority pending command.
package btn_pkg;

    localparam logic [2:0] CMD_NONE        = 3'd0;
    localparam logic [2:0] CMD_HEAL        = 3'd1;
    localparam logic [2:0] CMD_FEED        = 3'd2;
    localparam logic [2:0] CMD_RESET       = 3'd3;
    localparam logic [2:0] CMD_TEST_TOGGLE = 3'd4;
    localparam logic [2:0] CMD_TEST_STEP   = 3'd5;

    localparam int NUM_PEND = 5;

    // Priority: RESET > TEST_TOGGLE > HEAL > FEED > TEST_STEP
    localparam int P_STEP   = 0;
    localparam int P_FEED   = 1;
    localparam int P_HEAL   = 2;
    localparam int P_TOGGLE = 3;
    localparam int P_RESET  = 4;

    // One-hot mask of the highest-priority pending bit (zero if none).
    function automatic logic [NUM_PEND-1:0] pend_pick(input logic [NUM_PEND-1:0] pend);
        logic [NUM_PEND-1:0] mask;
        mask = '0;
        if (pend[P_RESET])       mask[P_RESET]  = 1'b1;
        else if (pend[P_TOGGLE]) mask[P_TOGGLE] = 1'b1;
        else if (pend[P_HEAL])   mask[P_HEAL]   = 1'b1;
        else if (pend[P_FEED])   mask[P_FEED]   = 1'b1;
        else if (pend[P_STEP])   mask[P_STEP]   = 1'b1;
        return mask;
    endfunction

    // Command code of the highest-priority pending bit (CMD_NONE if none).
    function automatic logic [2:0] pend_to_cmd(input logic [NUM_PEND-1:0] pend);
        logic [2:0] code;
        code = CMD_NONE;
        if (pend[P_RESET])       code = CMD_RESET;
        else if (pend[P_TOGGLE]) code = CMD_TEST_TOGGLE;
        else if (pend[P_HEAL])   code = CMD_HEAL;
        else if (pend[P_FEED])   code = CMD_FEED;
        else if (pend[P_STEP])   code = CMD_TEST_STEP;
        return code;
    endfunction

endpackage

// File: rtl/btn_cmd_decoder_if.sv
// rtl/btn_cmd_decoder_if.sv - command handshake bundle between decoder and game FSM
//
// Purpose: carries one command at a time under valid/ready.
//   cmd       : 3-bit command code (decoder -> consumer)
//   cmd_valid : cmd holds a command (decoder -> consumer)
//   cmd_ready : consumer accepts on the edge where valid && ready
// Modports: master = decoder side, slave = consumer side.
interface btn_cmd_decoder_if;
    logic [2:0] cmd;
    logic       cmd_valid;
    logic       cmd_ready;

    modport master (output cmd, output cmd_valid, input cmd_ready);
    modport slave  (input cmd, input cmd_valid, output cmd_ready);
endinterface

// File: rtl/btn_press_timer.sv
// rtl/btn_press_timer.sv - short/long press classifier for one debounced button
//
// Purpose: measures how long a button stays high and emits one pulse per press:
// long_evt on the LONG_CYCLES-th consecutive high sample, or short_evt on
// release if no long event fired during that press.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   btn       : debounced button level
//   short_evt : one-cycle pulse (combinational) on a short-press release
//   long_evt  : one-cycle pulse (combinational) at the long-press threshold
module btn_press_timer #(
    parameter int LONG_CYCLES = 3000,
    parameter int CNT_W       = 28
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic short_evt,
    output logic long_evt
);

    logic             prev;
    logic [CNT_W-1:0] cnt;
    // Set once the current press has produced an event (or the press began
    // before reset), so each press yields at most one event.
    logic             fired;

    assign long_evt  = btn && (cnt == CNT_W'(LONG_CYCLES - 1)) && !fired;
    assign short_evt = !btn && prev && !fired;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev  <= 1'b1;
            cnt   <= '0;
            fired <= 1'b1;
        end else begin
            prev <= btn;
            if (!btn) begin
                cnt   <= '0;
                fired <= 1'b0;
            end else begin
                if (cnt != '1)
                    cnt <= cnt + 1'b1;
                if (long_evt)
                    fired <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/btn_cmd_decoder.sv
// rtl/btn_cmd_decoder.sv - turns debounced button levels into single game commands
//
// Purpose: edge-detects heal/feed, classifies reset/test presses, tracks test
// mode, latches each command in a pending bit and delivers them one at a time
// in priority order through a single output slot.
// Ports:
//   clk, rst                           : clock, synchronous active-high reset
//   btn_salud/hambre/reset/test        : debounced button levels, active high
//   cmd_bus (master)                   : cmd / cmd_valid / cmd_ready handshake
//   test_mode                          : current test-mode level
module btn_cmd_decoder
    import btn_pkg::*;
#(
    parameter int LONG_CYCLES = 3000,
    parameter int CNT_W       = 28
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      btn_salud,
    input  logic                      btn_hambre,
    input  logic                      btn_reset,
    input  logic                      btn_test,
    btn_cmd_decoder_if.master         cmd_bus,
    output logic                      test_mode
);

    logic                prev_salud;
    logic                prev_hambre;
    logic                reset_short;
    logic                reset_long;
    logic                test_short;
    logic                test_long;
    logic                heal_evt;
    logic                feed_evt;
    logic                step_evt;
    logic [NUM_PEND-1:0] evts;
    logic [NUM_PEND-1:0] pend;
    logic [NUM_PEND-1:0] pend_n;
    logic                load;

    btn_press_timer #(.LONG_CYCLES(LONG_CYCLES), .CNT_W(CNT_W)) u_reset_timer (
        .clk       (clk),
        .rst       (rst),
        .btn       (btn_reset),
        .short_evt (reset_short),
        .long_evt  (reset_long)
    );

    btn_press_timer #(.LONG_CYCLES(LONG_CYCLES), .CNT_W(CNT_W)) u_test_timer (
        .clk       (clk),
        .rst       (rst),
        .btn       (btn_test),
        .short_evt (test_short),
        .long_evt  (test_long)
    );

    assign heal_evt = btn_salud & ~prev_salud;
    assign feed_evt = btn_hambre & ~prev_hambre;
    // A short test press only steps while already in test mode.
    assign step_evt = test_short & test_mode;

    always_comb begin
        evts           = '0;
        evts[P_RESET]  = reset_long;
        evts[P_TOGGLE] = test_long;
        evts[P_HEAL]   = heal_evt;
        evts[P_FEED]   = feed_evt;
        evts[P_STEP]   = step_evt;
    end

    assign load = !cmd_bus.cmd_valid || cmd_bus.cmd_ready;

    // Consume first, then apply RESET's flush, then set new events, so an
    // event on the same edge its bit is consumed is kept.
    always_comb begin
        pend_n = pend;
        if (load)
            pend_n = pend_n & ~pend_pick(pend);
        if (reset_long) begin
            pend_n[P_HEAL] = 1'b0;
            pend_n[P_FEED] = 1'b0;
            pend_n[P_STEP] = 1'b0;
        end
        pend_n = pend_n | evts;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_salud        <= 1'b1;
            prev_hambre       <= 1'b1;
            test_mode         <= 1'b0;
            pend              <= '0;
            cmd_bus.cmd       <= CMD_NONE;
            cmd_bus.cmd_valid <= 1'b0;
        end else begin
            prev_salud  <= btn_salud;
            prev_hambre <= btn_hambre;
            if (test_long)
                test_mode <= ~test_mode;
            pend <= pend_n;
            if (load) begin
                cmd_bus.cmd       <= pend_to_cmd(pend);
                cmd_bus.cmd_valid <= |pend;
            end
        end
    end

endmodule

// File: tb/tb_btn_cmd_decoder.sv
// tb/tb_btn_cmd_decoder.sv - directed self-checking bench for btn_cmd_decoder
module tb_btn_cmd_decoder;

    logic clk = 1'b0;
    logic rst;
    logic btn_salud;
    logic btn_hambre;
    logic btn_reset;
    logic btn_test;
    logic test_mode;

    int tests = 0;
    int fails = 0;

    logic [2:0] acc_q[$];

    btn_cmd_decoder_if bus ();

    btn_cmd_decoder #(.LONG_CYCLES(8), .CNT_W(28)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_salud  (btn_salud),
        .btn_hambre (btn_hambre),
        .btn_reset  (btn_reset),
        .btn_test   (btn_test),
        .cmd_bus    (bus),
        .test_mode  (test_mode)
    );

    always #5 clk = ~clk;

    // Inputs are stable between #1 after an edge and the next edge, so a
    // negedge observation of valid && ready is exactly one accepted command.
    always @(negedge clk) begin
        if (!rst && bus.cmd_valid && bus.cmd_ready)
            acc_q.push_back(bus.cmd);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_acc(input string tag, input int idx, input logic [2:0] exp);
        logic [2:0] v;
        v = (idx < acc_q.size()) ? acc_q[idx] : 3'd7;
        chk(tag, 32'(v), 32'(exp));
    endtask

    initial begin
        rst = 1'b1; btn_salud = 1'b0; btn_hambre = 1'b0;
        btn_reset = 1'b0; btn_test = 1'b0; bus.cmd_ready = 1'b1;
        tick(2);
        chk("reset_cmd", 32'(bus.cmd), 32'd0);
        chk("reset_valid", 32'(bus.cmd_valid), 32'd0);
        chk("reset_test_mode", 32'(test_mode), 32'd0);
        rst = 1'b0;
        tick(3);
        chk("idle_valid", 32'(bus.cmd_valid), 32'd0);
        acc_q.delete();

        // HEAL: 3-cycle pulse, one command two edges after the rise
        btn_salud = 1'b1;
        tick(1);
        chk("heal_lat1_valid", 32'(bus.cmd_valid), 32'd0);
        tick(1);
        chk("heal_lat2_valid", 32'(bus.cmd_valid), 32'd1);
        chk("heal_lat2_cmd", 32'(bus.cmd), 32'd1);
        tick(1);
        chk("heal_drop_valid", 32'(bus.cmd_valid), 32'd0);
        btn_salud = 1'b0;
        tick(3);
        chk("heal_count", 32'(acc_q.size()), 32'd1);
        chk_acc("heal_code", 0, 3'd1);
        acc_q.delete();

        // RESET: 20-cycle hold gives one RESET after the 8th sample
        btn_reset = 1'b1;
        tick(8);
        chk("rst_long_pre_valid", 32'(bus.cmd_valid), 32'd0);
        tick(1);
        chk("rst_long_valid", 32'(bus.cmd_valid), 32'd1);
        chk("rst_long_cmd", 32'(bus.cmd), 32'd3);
        tick(11);
        btn_reset = 1'b0;
        tick(3);
        chk("rst_long_count", 32'(acc_q.size()), 32'd1);
        chk_acc("rst_long_code", 0, 3'd3);
        acc_q.delete();

        // RESET: 5-cycle press is ignored
        btn_reset = 1'b1;
        tick(5);
        btn_reset = 1'b0;
        tick(5);
        chk("rst_short_count", 32'(acc_q.size()), 32'd0);

        // TEST: long press toggles mode on, short press steps
        btn_test = 1'b1;
        tick(7);
        chk("test_mode_pre", 32'(test_mode), 32'd0);
        tick(1);
        chk("test_mode_on", 32'(test_mode), 32'd1);
        tick(2);
        btn_test = 1'b0;
        tick(3);
        chk("toggle_count", 32'(acc_q.size()), 32'd1);
        chk_acc("toggle_code", 0, 3'd4);
        acc_q.delete();

        btn_test = 1'b1;
        tick(3);
        btn_test = 1'b0;
        tick(1);
        chk("step_lat1_valid", 32'(bus.cmd_valid), 32'd0);
        tick(1);
        chk("step_valid", 32'(bus.cmd_valid), 32'd1);
        chk("step_cmd", 32'(bus.cmd), 32'd5);
        tick(3);
        chk("step_count", 32'(acc_q.size()), 32'd1);
        acc_q.delete();

        // TEST: long press toggles mode off, then short press does nothing
        btn_test = 1'b1;
        tick(10);
        btn_test = 1'b0;
        tick(3);
        chk("test_mode_off", 32'(test_mode), 32'd0);
        chk_acc("toggle2_code", 0, 3'd4);
        acc_q.delete();
        btn_test = 1'b1;
        tick(3);
        btn_test = 1'b0;
        tick(4);
        chk("step_off_count", 32'(acc_q.size()), 32'd0);

        // Backpressure: slot held, HEAL coalesced while pending
        bus.cmd_ready = 1'b0;
        btn_salud = 1'b1;
        tick(1);
        btn_salud = 1'b0;
        tick(2);
        chk("hold_valid", 32'(bus.cmd_valid), 32'd1);
        chk("hold_cmd", 32'(bus.cmd), 32'd1);
        btn_salud = 1'b1; btn_hambre = 1'b1;
        tick(1);
        btn_salud = 1'b0;
        tick(1);
        btn_salud = 1'b1;
        tick(1);
        btn_salud = 1'b0; btn_hambre = 1'b0;
        tick(2);
        chk("hold_cmd_stable", 32'(bus.cmd), 32'd1);
        chk("hold_valid_stable", 32'(bus.cmd_valid), 32'd1);
        bus.cmd_ready = 1'b1;
        tick(5);
        chk("coal_count", 32'(acc_q.size()), 32'd3);
        chk_acc("coal_0", 0, 3'd1);
        chk_acc("coal_1", 1, 3'd1);
        chk_acc("coal_2", 2, 3'd2);
        acc_q.delete();

        // RESET flushes pending FEED while slot keeps HEAL
        bus.cmd_ready = 1'b0;
        btn_salud = 1'b1; btn_hambre = 1'b1;
        tick(1);
        btn_salud = 1'b0; btn_hambre = 1'b0;
        btn_reset = 1'b1;
        tick(8);
        btn_reset = 1'b0;
        tick(1);
        chk("flush_slot_cmd", 32'(bus.cmd), 32'd1);
        chk("flush_slot_valid", 32'(bus.cmd_valid), 32'd1);
        bus.cmd_ready = 1'b1;
        tick(4);
        chk("flush_count", 32'(acc_q.size()), 32'd2);
        chk_acc("flush_0", 0, 3'd1);
        chk_acc("flush_1", 1, 3'd3);
        acc_q.delete();

        // rst mid-handshake drops the slot; test held through rst
        bus.cmd_ready = 1'b0;
        btn_salud = 1'b1;
        tick(1);
        btn_salud = 1'b0;
        tick(1);
        chk("mid_valid", 32'(bus.cmd_valid), 32'd1);
        btn_test = 1'b1;
        rst = 1'b1;
        tick(1);
        chk("mid_rst_valid", 32'(bus.cmd_valid), 32'd0);
        chk("mid_rst_cmd", 32'(bus.cmd), 32'd0);
        tick(1);
        rst = 1'b0;
        bus.cmd_ready = 1'b1;
        tick(20);
        chk("held_test_mode", 32'(test_mode), 32'd0);
        chk("held_valid", 32'(bus.cmd_valid), 32'd0);
        btn_test = 1'b0;
        tick(2);
        chk("held_count", 32'(acc_q.size()), 32'd0);
        btn_test = 1'b1;
        tick(10);
        btn_test = 1'b0;
        tick(3);
        chk("after_hold_count", 32'(acc_q.size()), 32'd1);
        chk_acc("after_hold_code", 0, 3'd4);
        chk("after_hold_mode", 32'(test_mode), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
